// File: rtl/nn_layer_scheduler.sv
// Sequences N_LAYERS inference layers over one shared weight ROM port and one MultAdder.
// Define SCHED_TIMEOUT_EN to add a per-layer RUN watchdog that ends the pass in ERR.
module nn_layer_scheduler #(
    parameter int N_LAYERS       = 3,
    parameter int BIT            = 16,
    parameter int LANES          = 128,
    parameter int ADDR_W         = 11,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int AL_W          = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                          clk_i,
    input  logic                          iRst_n_i,
    input  logic                          start_i,
    input  logic [N_LAYERS-1:0]           layer_done_i,
    input  logic [N_LAYERS-1:0]           layer_overflow_i,
    input  logic [N_LAYERS*ADDR_W-1:0]    layer_addr_i,
    input  logic [N_LAYERS*LANES*BIT-1:0] layer_opr1_i,
    input  logic [N_LAYERS*LANES*BIT-1:0] layer_opr2_i,
    output logic [N_LAYERS-1:0]           layer_ena_o,
    output logic [N_LAYERS-1:0]           layer_rst_n_o,
    output logic [ADDR_W-1:0]             addr_to_rom_o,
    output logic [LANES*BIT-1:0]          opr1_to_MultAdder_o,
    output logic [LANES*BIT-1:0]          opr2_to_MultAdder_o,
    output logic [AL_W-1:0]               active_layer_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o,
    output logic                          error_o
);

    localparam int LB   = LANES * BIT;
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    if (RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("nn_layer_scheduler: RST_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, LRST, RUN, NEXT, FIN, ERR} state_t;

    state_t              state_q, state_d;
    logic [AL_W-1:0]     active_q, active_d;
    logic [RC_W-1:0]     rcnt_q, rcnt_d;
    logic [N_LAYERS-1:0] ena_q, ena_d;
    logic [N_LAYERS-1:0] rstn_q, rstn_d;
    logic [N_LAYERS-1:0] onehot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LB-1:0]       opr1_q, opr1_d;
    logic [LB-1:0]       opr2_q, opr2_d;
    logic                sel;

`ifdef SCHED_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TC_W-1:0] tcnt_q, tcnt_d;
    logic            error_q, error_d;
`endif

    // Enables are decoded from the next state so they line up with the registered state.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        rcnt_d   = '0;
        busy_d   = busy_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
`ifdef SCHED_TIMEOUT_EN
        tcnt_d   = '0;
        error_d  = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = LRST;
                    active_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    ovf_d    = 1'b0;
`ifdef SCHED_TIMEOUT_EN
                    error_d  = 1'b0;
`endif
                end
            end
            LRST: begin
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
                    rcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                ovf_d = ovf_q | layer_overflow_i[active_q];
                if (layer_done_i[active_q]) begin
                    state_d = NEXT;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (tcnt_q == TC_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR;
                end
                tcnt_d = tcnt_q + 1'b1;
`endif
            end
            NEXT: begin
                if (active_q == AL_W'(N_LAYERS - 1)) begin
                    state_d = FIN;
                end else begin
                    active_d = active_q + 1'b1;
                    state_d  = LRST;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ERR: begin
`ifdef SCHED_TIMEOUT_EN
                error_d = 1'b1;
`endif
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        onehot_d = N_LAYERS'(1) << active_d;
        ena_d    = (state_d == LRST || state_d == RUN) ? onehot_d : '0;
        rstn_d   = (state_d == LRST) ? ~onehot_d : '1;

        sel    = (state_q == LRST) || (state_q == RUN);
        addr_d = sel ? layer_addr_i[int'(active_q)*ADDR_W +: ADDR_W] : '0;
        opr1_d = sel ? layer_opr1_i[int'(active_q)*LB +: LB] : '0;
        opr2_d = sel ? layer_opr2_i[int'(active_q)*LB +: LB] : '0;
    end

    always_ff @(posedge clk_i or negedge iRst_n_i) begin
        if (!iRst_n_i) begin
            state_q  <= IDLE;
            active_q <= '0;
            rcnt_q   <= '0;
            ena_q    <= '0;
            rstn_q   <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            addr_q   <= '0;
            opr1_q   <= '0;
            opr2_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            rcnt_q   <= rcnt_d;
            ena_q    <= ena_d;
            rstn_q   <= rstn_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            addr_q   <= addr_d;
            opr1_q   <= opr1_d;
            opr2_q   <= opr2_d;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge iRst_n_i) begin
        if (!iRst_n_i) begin
            tcnt_q  <= '0;
            error_q <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            error_q <= error_d;
        end
    end
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    assign layer_ena_o         = ena_q;
    assign layer_rst_n_o       = rstn_q;
    assign addr_to_rom_o       = addr_q;
    assign opr1_to_MultAdder_o = opr1_q;
    assign opr2_to_MultAdder_o = opr2_q;
    assign active_layer_o      = active_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign overflow_o          = ovf_q;

endmodule

// File: tb/tb_nn_layer_scheduler.sv
// Self-checking bench for nn_layer_scheduler: behavioural layer models plus a
// per-pass schedule computed arithmetically from layer reset/run/next durations.
module tb_nn_layer_scheduler;

    localparam int N    = 3;
    localparam int BIT  = 16;
    localparam int LN   = 128;
    localparam int AW   = 11;
    localparam int RST  = 2;
    localparam int TMO  = 16;
    localparam int LB   = LN * BIT;
    localparam int ALW  = 2;

    logic              clk = 1'b0;
    logic              rstN;
    logic              start;
    logic [N-1:0]      layerDone;
    logic [N-1:0]      layerOvf;
    logic [N*AW-1:0]   layerAddr;
    logic [N*LB-1:0]   layerOpr1;
    logic [N*LB-1:0]   layerOpr2;
    logic [N-1:0]      layerEna;
    logic [N-1:0]      layerRstN;
    logic [AW-1:0]     addrToRom;
    logic [LB-1:0]     opr1Out;
    logic [LB-1:0]     opr2Out;
    logic [ALW-1:0]    activeLayer;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              error;

    int checks = 0;
    int errors = 0;

    int           dly[N];
    int           toLayer;
    int           cnt[N];
    logic [N-1:0] mDone;
    logic [AW-1:0] expAddr;
    logic [LB-1:0] expOpr1;
    logic [LB-1:0] expOpr2;
    logic          expOvf;
    bit            pulsed;

    nn_layer_scheduler #(
        .N_LAYERS(N), .BIT(BIT), .LANES(LN), .ADDR_W(AW),
        .RST_CYCLES(RST), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk),
        .iRst_n_i(rstN),
        .start_i(start),
        .layer_done_i(layerDone),
        .layer_overflow_i(layerOvf),
        .layer_addr_i(layerAddr),
        .layer_opr1_i(layerOpr1),
        .layer_opr2_i(layerOpr2),
        .layer_ena_o(layerEna),
        .layer_rst_n_o(layerRstN),
        .addr_to_rom_o(addrToRom),
        .opr1_to_MultAdder_o(opr1Out),
        .opr2_to_MultAdder_o(opr2Out),
        .active_layer_o(activeLayer),
        .busy_o(busy),
        .done_o(done),
        .overflow_o(overflow),
        .error_o(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkWide(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed_lo=%h expected_lo=%h", tag, obs[31:0], exp[31:0]);
        end
    endtask

    // Kind: 0 layer reset window, 1 run, 2 next, 3 fin/err, 4 idle after the pass.
    function automatic void phaseOf(input int t, output int lay, output int kind);
        int b;
        int rl;
        b = 0;
        lay = N - 1;
        kind = 4;
        for (int i = 0; i < N; i++) begin
            rl = (i == toLayer) ? TMO : dly[i] + 1;
            if (t < b + RST) begin lay = i; kind = 0; return; end
            if (t < b + RST + rl) begin lay = i; kind = 1; return; end
            if (t == b + RST + rl) begin lay = i; kind = (i == toLayer) ? 3 : 2; return; end
            if (i == toLayer) begin lay = i; kind = 4; return; end
            b = b + RST + rl + 1;
        end
        if (t == b) kind = 3;
    endfunction

    function automatic int termCycle();
        int b;
        int rl;
        b = 0;
        for (int i = 0; i < N; i++) begin
            rl = (i == toLayer) ? TMO : dly[i] + 1;
            if (i == toLayer) return b + RST + rl + 1;
            b = b + RST + rl + 1;
        end
        return b + 1;
    endfunction

    // Layer models react to their enables; new operand data is driven every cycle.
    task automatic applyStimulus(input int lay, input int kind, input logic [N-1:0] ovf, input bit fixedVals);
        logic [AW-1:0] a;
        logic [LB-1:0] o1;
        logic [LB-1:0] o2;
        for (int i = 0; i < N; i++) begin
            if (layerEna[i] && !layerRstN[i]) begin
                cnt[i] = 0;
                mDone[i] = 1'b0;
            end else if (layerEna[i] && layerRstN[i]) begin
                cnt[i]++;
                if (cnt[i] > dly[i]) mDone[i] = 1'b1;
            end
        end
        layerDone = mDone;
        layerOvf = ovf;
        expAddr = '0;
        expOpr1 = '0;
        expOpr2 = '0;
        for (int i = 0; i < N; i++) begin
            a = AW'($urandom);
            for (int w = 0; w < LB / 32; w++) begin
                o1[w*32 +: 32] = $urandom;
                o2[w*32 +: 32] = $urandom;
            end
            if (fixedVals && i == 0) a = 11'h123;
            if (fixedVals && i == 1) begin
                a = 11'h40b;
                o1[15:0] = 16'h3C00;
            end
            layerAddr[i*AW +: AW] = a;
            layerOpr1[i*LB +: LB] = o1;
            layerOpr2[i*LB +: LB] = o2;
            if (kind <= 1 && i == lay) begin
                expAddr = a;
                expOpr1 = o1;
                expOpr2 = o2;
            end
        end
        if (kind == 1 && ovf[lay]) expOvf = 1'b1;
    endtask

    task automatic checkOutput(input int lay, input int kind, input bit toPass);
        logic [N-1:0] eEna;
        logic [N-1:0] eRst;
        eEna = '0;
        eRst = '1;
        if (kind <= 1) eEna[lay] = 1'b1;
        if (kind == 0) eRst[lay] = 1'b0;
        check("layer_ena", 64'(layerEna), 64'(eEna));
        check("layer_rst_n", 64'(layerRstN), 64'(eRst));
        check("active_layer", 64'(activeLayer), 64'(lay));
        check("busy", 64'(busy), 64'(kind <= 3));
        check("done", 64'(done), 64'(kind == 4 && !toPass));
`ifdef SCHED_TIMEOUT_EN
        check("error", 64'(error), 64'(kind == 4 && toPass));
`else
        check("error", 64'(error), 64'(0));
`endif
        check("addr_to_rom", 64'(addrToRom), 64'(expAddr));
        checkWide("opr1", opr1Out, expOpr1);
        checkWide("opr2", opr2Out, expOpr2);
        check("overflow", 64'(overflow), 64'(expOvf));
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_ena"}, 64'(layerEna), 64'(0));
        check({tag, "_rst_n"}, 64'(layerRstN), 64'(3'b111));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
        check({tag, "_error"}, 64'(error), 64'(0));
        check({tag, "_active"}, 64'(activeLayer), 64'(0));
        check({tag, "_addr"}, 64'(addrToRom), 64'(0));
        checkWide({tag, "_opr1"}, opr1Out, '0);
    endtask

    // startMode 0 pulse, 1 hold, 2 random pulses mid-pass; ovfMode 0 random, 1 directed, 2 always.
    task automatic runPass(input int startMode, input bit keepStart, input int ovfMode,
                           input bit fixedVals, input int abortAt, input int toL);
        int tTerm;
        int lay;
        int kind;
        logic [N-1:0] ovf;
        toLayer = toL;
        tTerm = termCycle();
        pulsed = 1'b0;
        expOvf = 1'b0;
        start = 1'b1;
        applyStimulus(0, 4, '0, fixedVals);
        @(posedge clk);
        @(negedge clk);
        for (int t = 0; t < 4000; t++) begin
            phaseOf(t, lay, kind);
            if (t == abortAt) begin
                rstN = 1'b0;
                start = 1'b0;
                #1;
                checkResetState("abort");
                @(negedge clk);
                rstN = 1'b1;
                expAddr = '0;
                expOpr1 = '0;
                expOpr2 = '0;
                return;
            end
            checkOutput(lay, kind, toL >= 0);
            if (t >= tTerm) start = keepStart;
            else if (startMode == 1) start = 1'b1;
            else if (startMode == 2) start = ($urandom_range(2) == 0);
            else start = 1'b0;
            case (ovfMode)
                0: ovf = N'($urandom_range(7) == 0) | (N'($urandom_range(7) == 0) << 1) | (N'($urandom_range(7) == 0) << 2);
                1: begin
                    ovf = '0;
                    ovf[0] = !(lay == 0 && kind <= 1);
                    if (lay == 1 && kind == 1 && !pulsed) begin
                        ovf[1] = 1'b1;
                        pulsed = 1'b1;
                    end
                end
                default: ovf = '1;
            endcase
            applyStimulus(lay, kind, ovf, fixedVals);
            if (t == tTerm + (keepStart ? 0 : 1)) return;
            @(posedge clk);
            @(negedge clk);
        end
        check("pass_cycle_budget", 64'(1), 64'(0));
    endtask

    task automatic randomDelays(input int minD);
        for (int i = 0; i < N; i++) dly[i] = $urandom_range(14, minD);
    endtask

    initial begin
        rstN = 1'b1;
        start = 1'b0;
        layerDone = '0;
        layerOvf = '0;
        layerAddr = '0;
        layerOpr1 = '0;
        layerOpr2 = '0;
        mDone = '0;
        toLayer = -1;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            dly[i] = 10;
        end
        #1 rstN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] directed pass: fixed addresses, directed overflow pulses");
        runPass(0, 0, 1, 1, -1, -1);

        $display("[TB] random pass with stray start pulses");
        randomDelays(1);
        runPass(2, 0, 0, 0, -1, -1);

        $display("[TB] start held high across two back-to-back passes");
        randomDelays(1);
        runPass(1, 1, 0, 0, -1, -1);
        randomDelays(1);
        runPass(0, 0, 0, 0, -1, -1);

        $display("[TB] async reset during layer1 run, then a full pass");
        randomDelays(5);
        runPass(0, 0, 2, 0, RST + dly[0] + 2 + RST + 3, -1);
        randomDelays(1);
        runPass(0, 0, 0, 0, -1, -1);

`ifdef SCHED_TIMEOUT_EN
        $display("[TB] layer2 never finishes, watchdog pass");
        randomDelays(1);
        dly[2] = 100000;
        runPass(0, 0, 0, 0, -1, 2);
        randomDelays(1);
        runPass(0, 0, 0, 0, -1, -1);
`endif

        for (int k = 0; k < 3; k++) begin
            randomDelays(1);
            runPass(2, 0, 0, 0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
